// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//
// Frame sequencer for a helicopter game. Each frame draws every object
// in turn, waits for the frame-delay timer, erases every object, advances
// their positions for one cycle, then asks the collision checker for a result.
// A collision-free frame increments a saturating survival score; a collision
// ends the game until start is raised again.
//
// Parameters
//   NUM_OBJ  number of drawable objects (index 0 = helicopter), 2..16
//   SCORE_W  width of the survival score
//
// Ports
//   clock       rising-edge system clock
//   resetn      asynchronous active-low reset
//   start       begins a new game from IDLE or OVER
//   pause       holds the sequencer in HOLD while high
//   obj_done    per-object draw/erase complete, only bit [idx] is used
//   delayed     frame-delay timer expired
//   check_done  collision checker finished
//   collision   collision result, qualified by check_done
//   obj_en      one-hot enable of the object being drawn or erased
//   erase       high while erasing (background colour select)
//   delay_en    high while waiting on the frame-delay timer
//   delay_clr   one-cycle pulse on the first cycle of the wait
//   move_en     one-cycle pulse that advances object offsets
//   check       high while waiting on the collision checker
//   game_over   high after a collision
//   score       count of completed collision-free frames
//
// All outputs are decoded purely from registered state, so an asynchronous
// reset forces every output to zero at once.
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int NUM_OBJ = 4,
  parameter int SCORE_W = 16
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               pause,
  input  logic [NUM_OBJ-1:0] obj_done,
  input  logic               delayed,
  input  logic               check_done,
  input  logic               collision,
  output logic [NUM_OBJ-1:0] obj_en,
  output logic               erase,
  output logic               delay_en,
  output logic               delay_clr,
  output logic               move_en,
  output logic               check,
  output logic               game_over,
  output logic [SCORE_W-1:0] score
);

  localparam int                 IDX_W     = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_OBJ - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [NUM_OBJ-1:0] OBJ_ONE   = NUM_OBJ'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAW  = 3'd1,
    S_HOLD  = 3'd2,
    S_ERASE = 3'd3,
    S_MOVE  = 3'd4,
    S_CHECK = 3'd5,
    S_OVER  = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_score_nxt;
  // Set only on the cycle the sequencer enters HOLD, so delay_clr fires once
  // even when pause keeps the sequencer parked in HOLD for many cycles.
  logic               r_hold_first;
  logic               w_hold_first_nxt;
  logic               w_cur_done;

  assign w_cur_done = obj_done[r_idx];

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_score      <= '0;
      r_hold_first <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_score      <= w_score_nxt;
      r_hold_first <= w_hold_first_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_score_nxt      = r_score;
    w_hold_first_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_DRAW;
          w_idx_nxt   = '0;
          w_score_nxt = '0;
        end
      end
      S_DRAW: begin
        if (w_cur_done) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt      = S_HOLD;
            w_idx_nxt        = '0;
            w_hold_first_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_HOLD: begin
        if (delayed && !pause) begin
          w_state_nxt = S_ERASE;
        end
      end
      S_ERASE: begin
        if (w_cur_done) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_MOVE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_MOVE: begin
        w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (check_done) begin
          if (collision) begin
            w_state_nxt = S_OVER;
          end else begin
            w_state_nxt = S_DRAW;
            w_idx_nxt   = '0;
            if (r_score != SCORE_MAX) begin
              w_score_nxt = r_score + SCORE_W'(1);
            end
          end
        end
      end
      S_OVER: begin
        if (start) begin
          w_state_nxt = S_DRAW;
          w_idx_nxt   = '0;
          w_score_nxt = '0;
        end
      end
      default: begin
        // Illegal encoding: fall back to a clean idle state.
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    obj_en    = '0;
    erase     = 1'b0;
    delay_en  = 1'b0;
    delay_clr = 1'b0;
    move_en   = 1'b0;
    check     = 1'b0;
    game_over = 1'b0;
    case (r_state)
      S_DRAW: begin
        obj_en = OBJ_ONE << r_idx;
      end
      S_HOLD: begin
        delay_en  = 1'b1;
        delay_clr = r_hold_first;
      end
      S_ERASE: begin
        obj_en = OBJ_ONE << r_idx;
        erase  = 1'b1;
      end
      S_MOVE: begin
        move_en = 1'b1;
      end
      S_CHECK: begin
        check = 1'b1;
      end
      S_OVER: begin
        game_over = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign score = r_score;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//
// Drives two sequencers from the same inputs (default widths and a 3-bit
// score) and compares both against a behavioural frame model on every
// falling edge, plus directed scenarios with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start, pause, delayed, check_done, collision;
  logic [N-1:0] obj_done;

  logic [N-1:0] obj_en, obj_en3;
  logic         erase, delay_en, delay_clr, move_en, check, game_over;
  logic         erase3, delay_en3, delay_clr3, move_en3, check3, game_over3;
  logic [15:0]  score;
  logic [2:0]   score3;

  logic [5:0] flags, flags3;
  assign flags  = {erase, delay_en, delay_clr, move_en, check, game_over};
  assign flags3 = {erase3, delay_en3, delay_clr3, move_en3, check3, game_over3};

  always #5 clock = ~clock;

  game_sequencer #(.NUM_OBJ(N), .SCORE_W(16)) u_dut (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause),
    .obj_done(obj_done), .delayed(delayed), .check_done(check_done),
    .collision(collision), .obj_en(obj_en), .erase(erase),
    .delay_en(delay_en), .delay_clr(delay_clr), .move_en(move_en),
    .check(check), .game_over(game_over), .score(score)
  );

  game_sequencer #(.NUM_OBJ(N), .SCORE_W(3)) u_dut3 (
    .clock(clock), .resetn(resetn), .start(start), .pause(pause),
    .obj_done(obj_done), .delayed(delayed), .check_done(check_done),
    .collision(collision), .obj_en(obj_en3), .erase(erase3),
    .delay_en(delay_en3), .delay_clr(delay_clr3), .move_en(move_en3),
    .check(check3), .game_over(game_over3), .score(score3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural frame model ----------------
  localparam int P_IDLE = 0, P_DRAW = 1, P_HOLD = 2, P_ERASE = 3,
                 P_MOVE = 4, P_CHECK = 5, P_OVER = 6;
  int ph, mi, hc, ms, ms3;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ph <= P_IDLE; mi <= 0; hc <= 0; ms <= 0; ms3 <= 0;
    end else begin
      case (ph)
        P_IDLE, P_OVER: if (start) begin
          ph <= P_DRAW; mi <= 0; ms <= 0; ms3 <= 0;
        end
        P_DRAW, P_ERASE: if (obj_done[mi]) begin
          if (mi == N - 1) begin
            mi <= 0;
            hc <= 0;
            ph <= (ph == P_DRAW) ? P_HOLD : P_MOVE;
          end else begin
            mi <= mi + 1;
          end
        end
        P_HOLD: begin
          hc <= hc + 1;
          if (delayed && !pause) ph <= P_ERASE;
        end
        P_MOVE: ph <= P_CHECK;
        P_CHECK: if (check_done) begin
          if (collision) ph <= P_OVER;
          else begin
            ph  <= P_DRAW;
            ms  <= (ms  < 65535) ? ms + 1  : 65535;
            ms3 <= (ms3 < 7)     ? ms3 + 1 : 7;
          end
        end
        default: ph <= P_IDLE;
      endcase
    end
  end

  logic [N-1:0] e_obj_en;
  logic [5:0]   e_flags;
  always_comb begin
    e_obj_en = (ph == P_DRAW || ph == P_ERASE) ? N'(1 << mi) : '0;
    e_flags  = {ph == P_ERASE, ph == P_HOLD, (ph == P_HOLD) && (hc == 0),
                ph == P_MOVE, ph == P_CHECK, ph == P_OVER};
  end

  bit cmp_on = 1'b0;
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("m_obj_en",  32'(obj_en),  32'(e_obj_en));
      chk("m_flags",   32'(flags),   32'(e_flags));
      chk("m_score",   32'(score),   32'(ms));
      chk("m_obj_en3", 32'(obj_en3), 32'(e_obj_en));
      chk("m_flags3",  32'(flags3),  32'(e_flags));
      chk("m_score3",  32'(score3),  32'(ms3));
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed and random stimulus ----------------
  int exp_en [12] = '{1, 2, 4, 8, 0, 1, 2, 4, 8, 0, 0, 1};
  int exp_er [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  int exp_sc [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int n;
    int clr_cnt;
    resetn = 1'b0; start = 0; pause = 0; obj_done = '0;
    delayed = 0; check_done = 0; collision = 0;
    repeat (2) @(negedge clock);
    chk("rst_obj_en", 32'(obj_en), 0);
    chk("rst_flags",  32'(flags),  0);
    chk("rst_score",  32'(score),  0);
    resetn = 1'b1;
    cmp_on = 1'b1;

    // Idle with noisy inputs but no start: must stay idle
    repeat (4) begin
      @(negedge clock);
      pause = 1'($urandom); obj_done = N'($urandom);
      delayed = 1'($urandom); check_done = 1'($urandom); collision = 1'($urandom);
    end
    @(negedge clock);
    chk("idle_obj_en", 32'(obj_en), 0);
    chk("idle_flags",  32'(flags),  0);

    // One minimum-length frame
    obj_done = '1; delayed = 1; check_done = 1; collision = 0; pause = 0; start = 1;
    @(negedge clock);
    start = 0;
    for (int i = 0; i < 12; i++) begin
      chk("f1_obj_en", 32'(obj_en), 32'(exp_en[i]));
      chk("f1_erase",  32'(erase),  32'(exp_er[i]));
      chk("f1_score",  32'(score),  32'(exp_sc[i]));
      if (i == 4)  chk("f1_delay_clr", 32'(delay_clr), 1);
      if (i == 9)  chk("f1_move_en",   32'(move_en),   1);
      if (i == 10) chk("f1_check",     32'(check),     1);
      @(negedge clock);
    end

    // Pause held in HOLD
    pause = 1;
    n = 0;
    while (!delay_en && n < 20) begin @(negedge clock); n++; end
    chk("hold_reach", 32'(delay_en), 1);
    clr_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      clr_cnt += int'(delay_clr);
      chk("hold_stay", 32'(delay_en), 1);
      @(negedge clock);
    end
    clr_cnt += int'(delay_clr);
    chk("hold_clr_once", 32'(clr_cnt), 1);
    pause = 0;
    @(negedge clock);
    chk("pause_release_erase", 32'(erase), 1);
    chk("pause_release_en",    32'(obj_en), 1);

    // Run clean frames up to score 7, then collide
    n = 0;
    while (!(check && score == 16'd7) && n < 300) begin @(negedge clock); n++; end
    chk("reach_score7", 32'(check && score == 16'd7), 1);
    collision = 1;
    @(negedge clock);
    collision = 0;
    chk("over_flag",   32'(game_over), 1);
    chk("over_score",  32'(score),     7);
    chk("over_score3", 32'(score3),    7);
    repeat (3) @(negedge clock);
    chk("over_hold",       32'(game_over), 1);
    chk("over_hold_score", 32'(score),     7);
    start = 1;
    @(negedge clock);
    start = 0;
    chk("restart_en",    32'(obj_en),    1);
    chk("restart_score", 32'(score),     0);
    chk("restart_over",  32'(game_over), 0);

    // Nine clean frames: 3-bit score saturates at 7
    for (int f = 0; f < 9; f++) begin
      n = 0;
      while (!check && n < 30) begin @(negedge clock); n++; end
      @(negedge clock);
      chk("sat_score3", 32'(score3), (f + 1 > 7) ? 7 : f + 1);
      chk("sat_score",  32'(score),  f + 1);
    end

    // Only obj_done[idx] advances idx
    obj_done = 4'b0001;
    @(negedge clock);
    chk("idx1", 32'(obj_en), 2);
    obj_done = 4'b1101;
    @(negedge clock);
    chk("idx1_ignore_a", 32'(obj_en), 2);
    @(negedge clock);
    chk("idx1_ignore_b", 32'(obj_en), 2);
    obj_done = 4'b0010;
    @(negedge clock);
    chk("idx2", 32'(obj_en), 4);

    // Asynchronous reset mid-ERASE at idx 2
    obj_done = '1;
    n = 0;
    while (!(erase && obj_en == 4'd4) && n < 30) begin @(negedge clock); n++; end
    chk("erase_idx2_reach", 32'(erase && obj_en == 4'd4), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_obj_en", 32'(obj_en), 0);
    chk("arst_flags",  32'(flags),  0);
    chk("arst_score",  32'(score),  0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    chk("post_rst_idle_en",    32'(obj_en), 0);
    chk("post_rst_idle_flags", 32'(flags),  0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      #1;
      start      = ($urandom % 8) == 0;
      pause      = ($urandom % 4) == 0;
      obj_done   = N'($urandom);
      delayed    = 1'($urandom);
      check_done = 1'($urandom);
      collision  = ($urandom % 8) == 0;
      resetn     = !(($urandom % 400) == 0);
    end
    @(negedge clock);
    #1;
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter NUM_OBJ, default 4, number of drawable objects (index 0 = helicopter); legal range 2..16.
REQ-002 Parameter SCORE_W, default 16, width of the frame-survival score.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; leaves IDLE or OVER to begin a new game.
REQ-006 pause  input  1  level; holds the sequencer in HOLD while high.
REQ-007 obj_done  input  NUM_OBJ  per-object draw/erase complete; only bit [idx] is honoured.
REQ-008 delayed  input  1  frame-delay timer expired.
REQ-009 check_done  input  1  collision checker finished.
REQ-010 collision  input  1  collision result; valid only when check_done=1.
REQ-011 obj_en  output  NUM_OBJ  one-hot enable of the object currently being drawn or erased.
REQ-012 erase  output  1  high in ERASE; selects background colour.
REQ-013 delay_en  output  1  high in HOLD.
REQ-014 delay_clr  output  1  one-cycle pulse on the first HOLD cycle.
REQ-015 move_en  output  1  high in MOVE; advances object offsets.
REQ-016 check  output  1  high in CHECK.
REQ-017 game_over  output  1  high in OVER.
REQ-018 score  output  SCORE_W  count of completed collision-free frames.

Function
REQ-019 States: IDLE, DRAW, HOLD, ERASE, MOVE, CHECK, OVER; all outputs are decoded from registered state, idx and the HOLD-entry flag only.
REQ-020 idx is a ceil(log2(NUM_OBJ))-bit counter; in DRAW and ERASE, obj_en = one-hot(idx); in all other states obj_en = 0.
REQ-021 IDLE: start=1 -> DRAW, idx<=0, score<=0; otherwise remain.
REQ-022 DRAW: obj_done[idx]=1 with idx<NUM_OBJ-1 -> idx<=idx+1; with idx=NUM_OBJ-1 -> HOLD, idx<=0; obj_done bits other than [idx] are ignored.
REQ-023 HOLD: delay_clr=1 in the first cycle only; delayed=1 and pause=0 -> ERASE; delayed=1 with pause=1 -> remain in HOLD with no second delay_clr.
REQ-024 ERASE: same idx stepping as DRAW with erase=1; completion at idx=NUM_OBJ-1 -> MOVE, idx<=0.
REQ-025 MOVE: exactly one cycle, move_en=1, then -> CHECK.
REQ-026 CHECK: check_done=1 and collision=1 -> OVER, score unchanged; check_done=1 and collision=0 -> DRAW, score<=score+1 saturating at 2^SCORE_W-1; check_done=0 -> remain.
REQ-027 OVER: game_over=1, score held; start=1 -> DRAW, idx<=0, score<=0.
REQ-028 pause is ignored in every state except HOLD; start is ignored except in IDLE and OVER.
REQ-029 Unreachable state encodings recover to IDLE on the next clock.
REQ-030 Minimum frame length = 2*NUM_OBJ + 3 cycles (each obj_done high on its first enabled cycle, delayed high on the first HOLD cycle, check_done high on the first CHECK cycle).

Reset
REQ-031 resetn=0 forces IDLE, idx=0 and score=0 asynchronously, and drives all outputs to 0 regardless of the current state, including mid-DRAW or ERASE.
REQ-032 The first state change after resetn deasserts occurs on the first rising clock edge with start=1.

Verification
REQ-033 NUM_OBJ=4: start pulse, then obj_done always 1, delayed=1, check_done=1, collision=0 -> obj_en sequence 1,2,4,8, HOLD, then 1,2,4,8 with erase=1, move_en 1 cycle, check; score=1 after 11 cycles.
REQ-034 pause=1 held for 5 cycles in HOLD with delayed=1 -> remain in HOLD; delay_clr pulses once only; ERASE entered 1 cycle after pause falls.
REQ-035 Collision: check_done=1 and collision=1 at score=7 -> OVER with game_over=1 and score=7 held; a later start -> DRAW with score=0 and obj_en=1.
REQ-036 SCORE_W=3: 9 clean frames -> score sequence 1..7, then held at 7.
REQ-037 resetn low during ERASE at idx=2 -> all outputs 0 immediately; after release the block stays in IDLE until start.
REQ-038 In DRAW at idx=1, assert obj_done=4'b1101 -> no advance; assert 4'b0010 -> idx advances to 2.
